// File: rtl/tt_display_pkg.sv
// Shared types and default constants for the display scheduler.
package tt_display_pkg;

   // Scheduler states: dark idle, round-robin source shown, urgent byte shown, blank gap.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHOW   = 2'd1,
      ST_URGENT = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   localparam int DEF_NUM_SRC      = 4;
   localparam int DEF_DWELL_CYCLES = 1000;
   localparam int DEF_BLANK_CYCLES = 50;

   // Larger of two integers, used to size the shared dwell/gap timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// Combinational round-robin selector: first valid index strictly after 'last',
// wrapping modulo NUM_SRC. A sole valid source at 'last' is picked again.
module tt_rr_pick
   import tt_display_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int SEL_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] valid,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   grant,
   output logic               any_valid
);

   localparam int IW = SEL_W + 1;

   logic [IW-1:0] idx;

   // Scan offsets from farthest to nearest so the nearest valid index wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      grant = '0;
      idx   = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = {1'b0, last} + IW'(k);
         if (idx >= IW'(NUM_SRC)) begin
            idx = idx - IW'(NUM_SRC);
         end
         if (valid[idx[SEL_W-1:0]]) begin
            grant = idx[SEL_W-1:0];
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/tt_display_scheduler.sv
// Time-shares the two-digit hex display between NUM_SRC round-robin sources
// and one urgent requester, with a fixed dwell and a blank gap between grants.
module tt_display_scheduler
   import tt_display_pkg::*;
#(
   parameter int NUM_SRC      = DEF_NUM_SRC,
   parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int SEL_W        = $clog2(NUM_SRC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [8*NUM_SRC-1:0] src_data,
   input  logic                 urgent_req,
   input  logic [7:0]           urgent_data,
   output logic [3:0]           number1,
   output logic [3:0]           number2,
   output logic                 blank,
   output logic [SEL_W-1:0]     cur_src,
   output logic                 urgent_ack
);

   localparam int TMR_MAX = max_int(DWELL_CYCLES, BLANK_CYCLES);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] TMR_TOP    = TMR_W'(TMR_MAX - 1);
   localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'(DWELL_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit               HAS_GAP    = (BLANK_CYCLES > 0);

   state_t             state_q, state_nx;
   logic [TMR_W-1:0]   timer_q;
   logic [SEL_W-1:0]   last_ptr_q;
   logic [SEL_W-1:0]   rr_grant;
   logic               rr_any;
   logic               go_arb;
   logic               take_rr;
   logic               take_urgent;
   logic               timer_clr;
   logic               cur_valid;
   logic [SEL_W-1:0]   show_sel;
   logic [7:0]         show_byte;
   logic [7:0]         number_nx;
   logic               blank_nx;

   tt_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .valid     (src_valid),
      .last      (last_ptr_q),
      .grant     (rr_grant),
      .any_valid (rr_any)
   );

   assign cur_valid = src_valid[cur_src];
   // A fresh round-robin grant shows the newly picked source; otherwise the current one.
   assign show_sel  = take_rr ? rr_grant : cur_src;

   // Select the byte of the source about to be shown.
   always_comb begin
      show_byte = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (show_sel == SEL_W'(i)) begin
            show_byte = src_data[8*i +: 8];
         end
      end
   end

   // State, timer, pointer and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: every register here is control or output state, so all of it is reset; there is no memory array to leave unreset.
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         last_ptr_q <= SEL_W'(NUM_SRC - 1);
         cur_src    <= '0;
         number1    <= '0;
         number2    <= '0;
         blank      <= 1'b1;
         urgent_ack <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples values from before the edge.
         state_q <= state_nx;
         if (timer_clr) begin
            timer_q <= '0;
         end else if (timer_q != TMR_TOP) begin
            timer_q <= timer_q + TMR_W'(1);
         end
         if (take_rr) begin
            last_ptr_q <= rr_grant;
            cur_src    <= rr_grant;
         end
         number2    <= number_nx[7:4];
         number1    <= number_nx[3:0];
         blank      <= blank_nx;
         urgent_ack <= take_urgent;
      end
   end

   // Next-state: dwell/gap sequencing, urgent preemption and arbitration.
   always_comb begin
      state_nx    = state_q;
      go_arb      = 1'b0;
      take_rr     = 1'b0;
      take_urgent = 1'b0;

      case (state_q)
         ST_IDLE: go_arb = 1'b1;
         ST_SHOW: begin
            if (urgent_req) begin
               take_urgent = 1'b1;
            end else if (!cur_valid || timer_q == DWELL_LAST) begin
               if (HAS_GAP) state_nx = ST_GAP;
               else         go_arb   = 1'b1;
            end
         end
         ST_URGENT: begin
            // urgent_req is deliberately not looked at until the dwell ends.
            if (timer_q == DWELL_LAST) begin
               if (HAS_GAP) state_nx = ST_GAP;
               else         go_arb   = 1'b1;
            end
         end
         ST_GAP: begin
            if (urgent_req) begin
               take_urgent = 1'b1;
            end else if (timer_q == GAP_LAST) begin
               go_arb = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (go_arb) begin
         if (urgent_req)  take_urgent = 1'b1;
         else if (rr_any) take_rr     = 1'b1;
         else             state_nx    = ST_IDLE;
      end

      if (take_urgent) state_nx = ST_URGENT;
      if (take_rr)     state_nx = ST_SHOW;

      // Disable overrides everything and parks the scheduler dark.
      if (!enable) begin
         state_nx    = ST_IDLE;
         take_rr     = 1'b0;
         take_urgent = 1'b0;
      end

      // A re-grant of the same state still starts a new window.
      timer_clr = !enable || take_rr || take_urgent || (state_nx != state_q);
   end

   // Output values for the next cycle, derived from the state being entered.
   always_comb begin
      number_nx = {number2, number1};
      if (take_urgent) begin
         number_nx = urgent_data;
      end else if (state_nx == ST_SHOW) begin
         number_nx = show_byte;
      end
      blank_nx = !(state_nx == ST_SHOW || state_nx == ST_URGENT);
   end

endmodule

// File: tb/tb_tt_display_scheduler.sv
// Randomised and scenario-driven bench for tt_display_scheduler with a
// cycle-level reference model and a decoupled output scoreboard.
module tb_tt_display_scheduler;

   localparam int NUM_SRC = 4;
   localparam int DWELL   = 8;
   localparam int BLANK_N = 2;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [3:0]   src_valid;
   logic [31:0]  src_data;
   logic         urgent_req;
   logic [7:0]   urgent_data;
   logic [3:0]   number1;
   logic [3:0]   number2;
   logic         blank;
   logic [1:0]   cur_src;
   logic         urgent_ack;

   tt_display_scheduler #(
      .NUM_SRC      (NUM_SRC),
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLANK_N)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .urgent_req  (urgent_req),
      .urgent_data (urgent_data),
      .number1     (number1),
      .number2     (number2),
      .blank       (blank),
      .cur_src     (cur_src),
      .urgent_ack  (urgent_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       blank;
      logic       ack;
      logic [1:0] cur;
      logic [7:0] disp;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Reference model: what the display should look like, as a phase with a
   // countdown of cycles left to show.
   typedef enum {M_IDLE, M_SRC, M_URG, M_PAUSE} mmode_t;
   mmode_t     m_mode;
   int         m_left;
   logic [1:0] m_last;
   logic [1:0] m_cur;
   logic [7:0] m_byte;
   logic       m_blank;
   logic       m_ack;

   function automatic logic [7:0] byte_of(input int i);
      return src_data[8*i +: 8];
   endfunction

   task automatic begin_urgent();
      m_mode  = M_URG;
      m_left  = DWELL;
      m_byte  = urgent_data;
      m_blank = 1'b0;
      m_ack   = 1'b1;
   endtask

   task automatic arbitrate();
      int pick;
      pick = -1;
      if (urgent_req) begin
         begin_urgent();
      end else begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            int idx;
            idx = (int'(m_last) + k) % NUM_SRC;
            if (pick < 0 && src_valid[idx[1:0]]) pick = idx;
         end
         if (pick >= 0) begin
            m_mode  = M_SRC;
            m_left  = DWELL;
            m_last  = 2'(pick);
            m_cur   = 2'(pick);
            m_byte  = byte_of(pick);
            m_blank = 1'b0;
         end else begin
            m_mode  = M_IDLE;
            m_blank = 1'b1;
         end
      end
   endtask

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_edge();
      bit arb;
      bit done;
      arb  = 1'b0;
      done = 1'b0;
      if (rst) begin
         m_mode  = M_IDLE;
         m_left  = 0;
         m_last  = 2'(NUM_SRC - 1);
         m_cur   = 2'd0;
         m_byte  = 8'h00;
         m_blank = 1'b1;
         m_ack   = 1'b0;
      end else if (!enable) begin
         m_mode  = M_IDLE;
         m_blank = 1'b1;
         m_ack   = 1'b0;
      end else begin
         m_ack = 1'b0;
         case (m_mode)
            M_IDLE: arb = 1'b1;
            M_SRC: begin
               if (urgent_req) begin_urgent();
               else if (!src_valid[m_cur] || m_left == 1) done = 1'b1;
               else begin
                  m_left = m_left - 1;
                  m_byte = byte_of(int'(m_cur));
               end
            end
            M_URG: begin
               if (m_left == 1) done = 1'b1;
               else m_left = m_left - 1;
            end
            M_PAUSE: begin
               if (urgent_req) begin_urgent();
               else if (m_left == 1) arb = 1'b1;
               else m_left = m_left - 1;
            end
            default: arb = 1'b1;
         endcase
         if (done) begin
            if (BLANK_N > 0) begin
               m_mode  = M_PAUSE;
               m_left  = BLANK_N;
               m_blank = 1'b1;
            end else begin
               arb = 1'b1;
            end
         end
         if (arb) arbitrate();
      end
   endtask

   // One clock: update the model, then queue the expected post-edge outputs.
   task automatic step();
      obs_t e;
      model_edge();
      e.blank = m_blank;
      e.ack   = m_ack;
      e.cur   = m_cur;
      e.disp  = m_byte;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got blank=%0b ack=%0b cur=%0d num=%02h expected blank=%0b ack=%0b cur=%0d num=%02h",
                  name, got.blank, got.ack, got.cur, got.disp, exp.blank, exp.ack, exp.cur, exp.disp);
      end
   endtask

   // Monitor: compare every presented output cycle against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            obs_t e;
            obs_t g;
            e       = exp_q.pop_front();
            g.blank = blank;
            g.ack   = urgent_ack;
            g.cur   = cur_src;
            g.disp  = {number2, number1};
            check($sformatf("out_cyc%0d", cyc), g, e);
         end
      end
   end

   // Step until the model shows 'src' at 1-based dwell position 'pos'.
   task automatic wait_src(input int src, input int pos, input string name);
      int budget;
      budget = 200;
      while (!(m_mode == M_SRC && int'(m_cur) == src && (DWELL - m_left + 1) == pos) && budget > 0) begin
         step();
         budget--;
      end
      n_checks++;
      if (budget == 0) begin
         n_fail++;
         $display("FAIL %s got no src%0d dwell %0d within 200 cycles, expected it reached", name, src, pos);
      end
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b0;
      src_valid   = 4'h0;
      src_data    = 32'h7856_3412;
      urgent_req  = 1'b0;
      urgent_data = 8'h00;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      src_valid = 4'hF;
      repeat (2) step();

      // Full rotation 0x12, 0x34, 0x56, 0x78 and wrap.
      enable = 1'b1;
      repeat (45) step();

      // Only source 2 valid.
      src_valid = 4'b0100;
      repeat (35) step();

      // Urgent preemption during source 1.
      src_valid = 4'hF;
      wait_src(1, 3, "reach_src1_for_urgent");
      urgent_req  = 1'b1;
      urgent_data = 8'hAB;
      step();
      urgent_req = 1'b0;
      repeat (14) step();

      // Early drop of source 1.
      wait_src(1, 4, "reach_src1_for_drop");
      src_valid = 4'b1101;
      repeat (6) step();
      src_valid = 4'hF;

      // Disable during source 3, then re-enable.
      wait_src(3, 2, "reach_src3_for_disable");
      enable = 1'b0;
      repeat (3) step();
      enable = 1'b1;
      repeat (12) step();

      // Reset during an urgent window.
      urgent_req  = 1'b1;
      urgent_data = 8'hC5;
      step();
      urgent_req = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (12) step();

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) src_valid = 4'($urandom);
         if ($urandom_range(0, 3) == 0) src_data = $urandom;
         urgent_req  = ($urandom_range(0, 29) == 0);
         urgent_data = 8'($urandom);
         enable      = ($urandom_range(0, 49) != 0);
         rst         = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
